// File: rtl/mcs51_pkg.sv
// ---------------------------------------------------------------------------
// mcs51_pkg -- shared types and helpers for the MCS-51 style blocks.
//
// Contents used by the interrupt controller:
//   intc_state_e    : two-state request FSM encoding (INTC_IDLE, INTC_REQ)
//   INTC_VEC_STRIDE : default byte spacing between interrupt vectors
//   intc_vec()      : vector address = base + id * stride, wrapped to 16 bits
// ---------------------------------------------------------------------------
package mcs51_pkg;

    typedef enum logic {
        INTC_IDLE = 1'b0,
        INTC_REQ  = 1'b1
    } intc_state_e;

    localparam int INTC_VEC_STRIDE = 8;

    // The sum is formed at 32 bits and only the low 16 bits are kept, so a
    // large id/stride product wraps around the 64K code space.
    function automatic logic [15:0] intc_vec(input logic [15:0] base,
                                             input logic [3:0]  id,
                                             input int          stride);
        logic [31:0] sum;
        sum = 32'(base) + 32'(id) * 32'(stride);
        return sum[15:0];
    endfunction

endpackage

// File: rtl/mcs51_intc_arb.sv
// ---------------------------------------------------------------------------
// mcs51_intc_arb -- combinational priority arbiter for mcs51_intc.
//
// Ports:
//   eligible    in  NUM_SRC     pending & enabled sources
//   prio        in  NUM_SRC*LW  priority level per source (saturated here)
//   isr         in  NUM_LVL     in-service bit per level
//   win_id      out 4           winning source index
//   win_lvl     out LW          level of the winning source
//   presentable out 1           a winner exists and outranks every active ISR
// ---------------------------------------------------------------------------
module mcs51_intc_arb #(
    parameter int NUM_SRC = 5,
    parameter int NUM_LVL = 2,
    parameter int LW      = $clog2(NUM_LVL)
) (
    input  logic [NUM_SRC-1:0]    eligible,
    input  logic [NUM_SRC*LW-1:0] prio,
    input  logic [NUM_LVL-1:0]    isr,
    output logic [3:0]            win_id,
    output logic [LW-1:0]         win_lvl,
    output logic                  presentable
);

    logic          found;
    logic [LW-1:0] lvl;
    logic          isr_any;
    logic [LW-1:0] isr_top;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch to hold the old value.
        found   = 1'b0;
        win_id  = '0;
        win_lvl = '0;
        lvl     = '0;
        isr_any = 1'b0;
        isr_top = '0;

        // Scan from the highest index down and accept ties, so the lowest
        // index among equal levels is the last one written and wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            lvl = prio[i*LW +: LW];
            if (int'(lvl) >= NUM_LVL) begin
                lvl = LW'(NUM_LVL - 1);
            end
            if (eligible[i] && (!found || lvl >= win_lvl)) begin
                found   = 1'b1;
                win_id  = 4'(i);
                win_lvl = lvl;
            end
        end

        for (int j = 0; j < NUM_LVL; j++) begin
            if (isr[j]) begin
                isr_any = 1'b1;
                isr_top = LW'(j);
            end
        end

        presentable = found && (!isr_any || win_lvl > isr_top);
    end

endmodule

// File: rtl/mcs51_intc.sv
// ---------------------------------------------------------------------------
// mcs51_intc -- MCS-51 style interrupt controller with nested priority levels.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_i               raw request per source
//   edge_i              1 = rising-edge triggered, 0 = level triggered
//   en_i, ea_i          per-source enable, global enable
//   prio_i              LW-bit priority level per source
//   sw_set_i, sw_clr_i  software set/clear of edge-pending flags
//   irq_ack_i, reti_i   CPU accepts request / CPU returned from ISR
//   irq_req_o           registered request to the CPU
//   irq_id_o, irq_vec_o registered winning source index and vector
//   pend_o, isr_o       pending flags and in-service bits for readback
//
// Build option: define MCS51_INTC_SYNC_EN to pass src_i through a 2-flop
// synchronizer first (src-to-request latency 4 cycles instead of 2).
// ---------------------------------------------------------------------------
module mcs51_intc
    import mcs51_pkg::*;
#(
    parameter int          NUM_SRC    = 5,
    parameter int          NUM_LVL    = 2,
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int          VEC_STRIDE = INTC_VEC_STRIDE,
    localparam int         LW         = $clog2(NUM_LVL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_i,
    input  logic [NUM_SRC-1:0]    edge_i,
    input  logic [NUM_SRC-1:0]    en_i,
    input  logic                  ea_i,
    input  logic [NUM_SRC*LW-1:0] prio_i,
    input  logic [NUM_SRC-1:0]    sw_set_i,
    input  logic [NUM_SRC-1:0]    sw_clr_i,
    input  logic                  irq_ack_i,
    input  logic                  reti_i,
    output logic                  irq_req_o,
    output logic [3:0]            irq_id_o,
    output logic [15:0]           irq_vec_o,
    output logic [NUM_SRC-1:0]    pend_o,
    output logic [NUM_LVL-1:0]    isr_o
);

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_LVL-1:0] isr_q, isr_d;
    logic               clr_done;
    intc_state_e        state_q, state_d;
    logic [3:0]         id_q;
    logic [15:0]        vec_q;
    logic [LW-1:0]      lvl_q;
    logic [3:0]         win_id;
    logic [LW-1:0]      win_lvl;
    logic               presentable;
    logic               ack_fire;

`ifdef MCS51_INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src_i;
`endif

    // prev_q resets to 0, so a source already high at reset release is
    // seen as a fresh rising edge.
    assign rise     = src_s & ~prev_q;
    assign eligible = pend_q & en_i & {NUM_SRC{ea_i}};
    assign ack_fire = irq_ack_i && (state_q == INTC_REQ);

    mcs51_intc_arb #(
        .NUM_SRC (NUM_SRC),
        .NUM_LVL (NUM_LVL),
        .LW      (LW)
    ) u_arb (
        .eligible    (eligible),
        .prio        (prio_i),
        .isr         (isr_q),
        .win_id      (win_id),
        .win_lvl     (win_lvl),
        .presentable (presentable)
    );

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ack_fire && id_q == 4'(i)) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Edge sources: a new edge or software set beats any clear in the same
    // cycle. Level sources simply follow the (synchronized) request line.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_i[i]) begin
                if (rise[i] || sw_set_i[i]) begin
                    pend_d[i] = 1'b1;
                end else if (ack_clr[i] || sw_clr_i[i]) begin
                    pend_d[i] = 1'b0;
                end
            end else begin
                pend_d[i] = src_s[i];
            end
        end
    end

    // RETI retires the highest active level first; an ack in the same cycle
    // then marks the newly accepted level.
    always_comb begin
        isr_d    = isr_q;
        clr_done = 1'b0;
        for (int j = NUM_LVL - 1; j >= 0; j--) begin
            if (reti_i && !clr_done && isr_q[j]) begin
                isr_d[j] = 1'b0;
                clr_done = 1'b1;
            end
        end
        if (ack_fire) begin
            isr_d[lvl_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INTC_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs, independent of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INTC_IDLE: if (presentable) state_d = INTC_REQ;
            INTC_REQ:  if (ack_fire || !presentable) state_d = INTC_IDLE;
            default:   state_d = INTC_IDLE;
        endcase
    end

    always_comb begin
        irq_req_o = (state_q == INTC_REQ);
    end

    // id/vector/level track the live winner whenever a request will be shown
    // next cycle, so a higher-priority arrival replaces the presented one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
            isr_q  <= '0;
            id_q   <= '0;
            vec_q  <= '0;
            lvl_q  <= '0;
        end else begin
            prev_q <= src_s;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            if (state_d == INTC_REQ) begin
                id_q  <= win_id;
                vec_q <= intc_vec(VEC_BASE, win_id, VEC_STRIDE);
                lvl_q <= win_lvl;
            end
        end
    end

    assign irq_id_o  = id_q;
    assign irq_vec_o = vec_q;
    assign pend_o    = pend_q;
    assign isr_o     = isr_q;

endmodule
